// File: rtl/jk_bank_arbiter.sv
// Four-requester arbiter owning a shared JK register bank; each grant applies one masked JK op.
// Define JK_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [7:0]           op,
  input  logic [4*WIDTH-1:0]   mask,
  output logic [3:0]           grant,
  output logic                 done,
  output logic                 busy,
  output logic [WIDTH-1:0]     q
);

  typedef enum logic [1:0] {IDLE, GRANT, APPLY, RELEASE} state_t;

  state_t           state_q;
  logic [3:0]       grant_q;
  logic             done_q;
  logic [WIDTH-1:0] bank_q, j_q, k_q;
  logic [1:0]       win_q, win_d;
  logic [WIDTH-1:0] sel_mask;
  logic [1:0]       sel_op;
`ifndef JK_ARB_FIXED_PRIO_EN
  logic [1:0]       last_q;
`endif

  // Winner selection; later loop iterations override, so the first in search order wins.
  always_comb begin
    win_d = 2'd0;
`ifdef JK_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--)
      if (req[i]) win_d = 2'(i);
`else
    for (int i = 4; i >= 1; i--) begin
      logic [1:0] cand;
      cand = last_q + 2'(i);
      if (req[cand]) win_d = cand;
    end
`endif
  end

  always_comb begin
    sel_mask = '0;
    sel_op   = 2'b00;
    for (int i = 0; i < 4; i++)
      if (win_q == 2'(i)) begin
        sel_mask = mask[i*WIDTH +: WIDTH];
        sel_op   = op[2*i +: 2];
      end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      done_q  <= 1'b0;
      bank_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      win_q   <= 2'd0;
`ifndef JK_ARB_FIXED_PRIO_EN
      last_q  <= 2'd3;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          win_q   <= win_d;
          grant_q <= 4'b0001 << win_d;
          state_q <= GRANT;
`ifndef JK_ARB_FIXED_PRIO_EN
          last_q  <= win_d;
`endif
        end
        GRANT: begin
          // op bit1 drives J, bit0 drives K: 00 hold, 01 clear, 10 set, 11 toggle
          j_q     <= sel_mask & {WIDTH{sel_op[1]}};
          k_q     <= sel_mask & {WIDTH{sel_op[0]}};
          state_q <= APPLY;
        end
        APPLY: begin
          bank_q  <= (j_q & ~bank_q) | (~k_q & bank_q);
          done_q  <= 1'b1;
          state_q <= RELEASE;
        end
        RELEASE: if (!req[win_q]) begin
          grant_q <= 4'b0000;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= 4'b0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign q     = bank_q;

endmodule
